// File: rtl/fir3_out_serializer.sv
// Serializes 3-sample words from the 3-parallel FIR into a single-rate valid/ready stream.
// A small word FIFO absorbs bursts, and a sticky flag records any word lost to overflow.
module fir3_out_serializer #(
    parameter int unsigned NBIT = 8,
    parameter int unsigned AW   = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VIN,
    input  logic [NBIT-1:0] DIN3k,
    input  logic [NBIT-1:0] DIN3k1,
    input  logic [NBIT-1:0] DIN3k2,
    input  logic            READY,
    output logic [NBIT-1:0] DOUT,
    output logic            VOUT,
    output logic            FULL,
    output logic [AW:0]     LEVEL,
    output logic            OVF
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned WW    = 3 * NBIT;

    typedef enum logic [1:0] {
        LANE_0 = 2'd0,
        LANE_1 = 2'd1,
        LANE_2 = 2'd2
    } lane_t;

    lane_t           lane;
    lane_t           lane_nxt;
    logic [WW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;
    logic            ovf;
    logic            xfer;
    logic            pop;
    logic            push;
    logic [WW-1:0]   head;
    logic [NBIT-1:0] lane_data;

    assign xfer = VOUT & READY;
    assign pop  = xfer & (lane == LANE_2);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push = VIN & ((level < (AW+1)'(DEPTH)) | pop);

    // Lane is packed with sample 3k in the low bits.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {DIN3k2, DIN3k1, DIN3k};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (VIN & ~push) begin
                ovf <= 1'b1;
            end
        end
    end

    // Lane counter state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane <= LANE_0;
        end else begin
            lane <= lane_nxt;
        end
    end

    always_comb begin
        lane_nxt = lane;
        if (xfer) begin
            case (lane)
                LANE_0:  lane_nxt = LANE_1;
                LANE_1:  lane_nxt = LANE_2;
                LANE_2:  lane_nxt = LANE_0;
                default: lane_nxt = LANE_0;
            endcase
        end
    end

    // Outputs derive from registered state only; no input-to-output path.
    always_comb begin
        head      = mem[rd_ptr];
        lane_data = '0;
        case (lane)
            LANE_0:  lane_data = head[NBIT-1:0];
            LANE_1:  lane_data = head[2*NBIT-1:NBIT];
            LANE_2:  lane_data = head[3*NBIT-1:2*NBIT];
            default: lane_data = '0;
        endcase
    end

    assign VOUT  = (level != '0);
    assign DOUT  = VOUT ? lane_data : '0;
    assign FULL  = (level == (AW+1)'(DEPTH));
    assign LEVEL = level;
    assign OVF   = ovf;

endmodule

// File: tb/tb_fir3_out_serializer.sv
// Scoreboard bench for fir3_out_serializer: expected samples are queued at push time
// and compared whenever the DUT presents valid output.
module tb_fir3_out_serializer;

    localparam int unsigned NBIT  = 8;
    localparam int unsigned AW    = 2;
    localparam int          DEPTH = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic            VIN;
    logic [NBIT-1:0] DIN3k;
    logic [NBIT-1:0] DIN3k1;
    logic [NBIT-1:0] DIN3k2;
    logic            READY;
    logic [NBIT-1:0] DOUT;
    logic            VOUT;
    logic            FULL;
    logic [AW:0]     LEVEL;
    logic            OVF;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NBIT-1:0] sb[$];
    int mlevel;
    int mlane;
    int movf;

    fir3_out_serializer #(.NBIT(NBIT), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .VIN(VIN),
        .DIN3k(DIN3k), .DIN3k1(DIN3k1), .DIN3k2(DIN3k2),
        .READY(READY), .DOUT(DOUT), .VOUT(VOUT),
        .FULL(FULL), .LEVEL(LEVEL), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Async reset asserted mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; VIN = 1'b0; READY = 1'b0;
        #1;
        check("rst_vout", int'(VOUT), 0);
        check("rst_level", int'(LEVEL), 0);
        check("rst_ovf", int'(OVF), 0);
        check("rst_full", int'(FULL), 0);
        check("rst_dout", int'(DOUT), 0);
        sb.delete();
        mlevel = 0; mlane = 0; movf = 0;
        #1 RST = 1'b0;
    endtask

    // One cycle: drive inputs after negedge, check outputs, then advance the model.
    task automatic step(input logic vin, input int a, input int b, input int c, input logic rdy);
        logic mpop;
        logic mpush;
        @(negedge CLK);
        VIN = vin; READY = rdy;
        DIN3k = NBIT'(a); DIN3k1 = NBIT'(b); DIN3k2 = NBIT'(c);
        #1;
        check("vout", int'(VOUT), int'(mlevel != 0));
        check("dout", int'(DOUT), (mlevel != 0) ? int'(sb[0]) : 0);
        check("level", int'(LEVEL), mlevel);
        check("full", int'(FULL), int'(mlevel == DEPTH));
        check("ovf", int'(OVF), movf);
        mpop = 1'b0;
        if (mlevel != 0 && rdy) begin
            void'(sb.pop_front());
            if (mlane == 2) begin
                mlane = 0;
                mpop  = 1'b1;
            end else begin
                mlane++;
            end
        end
        mpush = vin && (mlevel < DEPTH || mpop);
        if (mpush) begin
            sb.push_back(NBIT'(a)); sb.push_back(NBIT'(b)); sb.push_back(NBIT'(c));
        end else if (vin) begin
            movf = 1;
        end
        mlevel = mlevel + int'(mpush) - int'(mpop);
    endtask

    initial begin
        RST = 1'b1; VIN = 1'b0; READY = 1'b0;
        DIN3k = '0; DIN3k1 = '0; DIN3k2 = '0;
        do_reset();

        // Single word, sink always ready
        step(1'b1, 10, 20, 30, 1'b1);
        repeat (4) step(1'b0, 0, 0, 0, 1'b1);
        check("t1_level", int'(LEVEL), 0);

        // Backpressure holds the first sample stable
        step(1'b1, 1, 2, 3, 1'b0);
        repeat (5) step(1'b0, 0, 0, 0, 1'b0);
        repeat (4) step(1'b0, 0, 0, 0, 1'b1);

        // Fill to full, overflow one word, drain
        for (int w = 0; w < 4; w++) step(1'b1, 40 + 3*w, 41 + 3*w, 42 + 3*w, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        check("t3_full", int'(FULL), 1);
        check("t3_level4", int'(LEVEL), 4);
        step(1'b1, 99, 98, 97, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        check("t3_ovf", int'(OVF), 1);
        check("t3_level_kept", int'(LEVEL), 4);
        repeat (14) step(1'b0, 0, 0, 0, 1'b1);
        check("t3_drained", sb.size(), 0);

        // Full FIFO: push coincides with pop of the head's last lane
        do_reset();
        for (int w = 0; w < 4; w++) step(1'b1, 100 + 3*w, 101 + 3*w, 102 + 3*w, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b1, 200, 201, 202, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0);
        check("t4_level", int'(LEVEL), 4);
        check("t4_ovf", int'(OVF), 0);
        repeat (14) step(1'b0, 0, 0, 0, 1'b1);
        check("t4_drained", sb.size(), 0);

        // Reset in the middle of a word with others queued
        step(1'b1, 50, 51, 52, 1'b0);
        step(1'b1, 53, 54, 55, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1);
        do_reset();
        step(1'b1, 60, 61, 62, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0);
        check("t5_first", int'(DOUT), 60);
        repeat (4) step(1'b0, 0, 0, 0, 1'b1);

        // Steady one-in-three word rate, random data
        for (int w = 0; w < 100; w++) begin
            step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b1);
            if (w > 0) check("t6_level_le1", int'(LEVEL <= 1), 1);
            step(1'b0, 0, 0, 0, 1'b1);
            step(1'b0, 0, 0, 0, 1'b1);
        end
        repeat (4) step(1'b0, 0, 0, 0, 1'b1);
        check("t6_ovf", int'(OVF), 0);
        check("t6_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
